counter_sequencer: RTL and testbench

- Controller for the 8-bit T-flip-flop counter.
- Turns raw active-low push-button commands (start, stop, clear) into a divided-rate, one-cycle count-enable stream and a clear pulse.
- Monitors the counter value and stops or wraps it at a programmable target.
- Sits between the board KEY/SW inputs and the counter's enable/clear_b pins. The counter shares `clock`.

---
 rtl/counter_sequencer.sv | 150 +++++++++++++++
 tb/tb_counter_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Sequencer for the 8-bit T-flip-flop counter: button commands,
// rate divider, terminal stop/wrap and registered counter clear.
//
// Ports:
//   clock, reset_n        clock, async active-low reset
//   start_n/stop_n/clear_n raw active-low push buttons
//   rate_sel [1:0]        divider reload select (RATE0..RATE3)
//   target [7:0]          terminal count (live)
//   wrap_en               1: clear and continue, 0: stop at target
//   count_q [7:0]         counter value
//   count_en              one-cycle counter enable
//   count_clear_b         registered active-low counter clear
//   busy / done           state==RUN / state==DONE
//   state [1:0]           IDLE=0 RUN=1 PAUSE=2 DONE=3
module counter_sequencer #(
  parameter int DIV_W = 26,
  parameter int RATE0 = 0,
  parameter int RATE1 = 12499999,
  parameter int RATE2 = 24999999,
  parameter int RATE3 = 49999999
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_n,
  input  logic       stop_n,
  input  logic       clear_n,
  input  logic [1:0] rate_sel,
  input  logic [7:0] target,
  input  logic       wrap_en,
  input  logic [7:0] count_q,
  output logic       count_en,
  output logic       count_clear_b,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // bit 0 start, bit 1 stop, bit 2 clear
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_s3;
  logic [2:0] w_pulse;
  logic       w_clr;
  logic       w_stop;
  logic       w_start;
  logic       w_cmd;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_reload;
  logic             w_tick;
  logic             w_term;
  logic             w_go;
  logic             r_clr_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '1;
      r_s2 <= '1;
      r_s3 <= '1;
    end else begin
      r_s1 <= {clear_n, stop_n, start_n};
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Falling edge of the synchronized level: one pulse per press.
  assign w_pulse = r_s3 & ~r_s2;
  assign w_clr   = w_pulse[2];
  assign w_stop  = w_pulse[1];
  assign w_start = w_pulse[0];
  assign w_cmd   = |w_pulse;

  always_comb begin
    w_reload = DIV_W'(RATE0);
    unique case (rate_sel)
      2'd0: w_reload = DIV_W'(RATE0);
      2'd1: w_reload = DIV_W'(RATE1);
      2'd2: w_reload = DIV_W'(RATE2);
      2'd3: w_reload = DIV_W'(RATE3);
      default: w_reload = DIV_W'(RATE0);
    endcase
  end

  assign w_tick = (r_state == RUN) && (r_div == '0);
  // A pending command always outranks the terminal match.
  assign w_term = (r_state == RUN) && (count_q == target) && !w_cmd;
  assign w_go   = (w_next == RUN) && (r_state != RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    priority case (1'b1)
      w_clr: w_next = IDLE;
      w_stop: begin
        if (r_state == RUN) w_next = PAUSE;
      end
      w_start: begin
        if (r_state == IDLE || r_state == PAUSE) w_next = RUN;
      end
      (w_term && !wrap_en): w_next = DONE;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= DIV_W'(RATE0);
    end else if (w_clr || w_go || w_tick) begin
      r_div <= w_reload;
    end else if (r_state == RUN) begin
      r_div <= r_div - DIV_W'(1);
    end
  end

  // Held low through reset; one low cycle per clear or wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_b <= 1'b0;
    end else begin
      r_clr_b <= ~(w_clr | (w_term & wrap_en));
    end
  end

  always_comb begin
    state         = r_state;
    busy          = (r_state == RUN);
    done          = (r_state == DONE);
    count_clear_b = r_clr_b;
    count_en      = w_tick && (count_q != target) && r_clr_b;
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: behavioural counter, cycle model,
// directed scenarios and randomized button traffic.
module tb_counter_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       start_n = 1'b1;
  logic       stop_n = 1'b1;
  logic       clear_n = 1'b1;
  logic [1:0] rate_sel = 2'd0;
  logic [7:0] target = 8'd0;
  logic       wrap_en = 1'b0;
  logic [7:0] cq;
  logic       count_en;
  logic       count_clear_b;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  counter_sequencer #(
    .DIV_W(26), .RATE0(0), .RATE1(1), .RATE2(3), .RATE3(7)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start_n(start_n),
    .stop_n(stop_n),
    .clear_n(clear_n),
    .rate_sel(rate_sel),
    .target(target),
    .wrap_en(wrap_en),
    .count_q(cq),
    .count_en(count_en),
    .count_clear_b(count_clear_b),
    .busy(busy),
    .done(done),
    .state(state)
  );

  // The counter being controlled: async active-low clear.
  always_ff @(posedge clock or negedge count_clear_b) begin
    if (!count_clear_b) cq <= 8'd0;
    else if (count_en) cq <= cq + 8'd1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int rate_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 1 : (s == 2) ? 3 : 7;
  endfunction

  // Model: state as integers, divider as elapsed cycles vs period,
  // button history as the last three sampled levels.
  int m_state, m_q, m_el, m_per;
  bit m_clrb, m_ok = 0;
  bit [2:0] h1, h2, h3;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_clrb = 0; m_q = 0;
      m_el = 0; m_per = 1;
      h1 = '1; h2 = '1; h3 = '1;
      m_ok = 1;
    end else if (m_ok) begin
      bit [2:0] p;
      bit tk, en, term, rl;
      int ns;
      p = h3 & ~h2;
      tk = (m_state == 1) && (m_el == m_per - 1);
      en = tk && (m_q != int'(target)) && m_clrb;
      term = (m_state == 1) && (m_q == int'(target)) && (p == 0);
      ns = m_state;
      if (p[2]) ns = 0;
      else if (p[1]) begin
        if (m_state == 1) ns = 2;
      end else if (p[0]) begin
        if (m_state == 0 || m_state == 2) ns = 1;
      end else if (term && !wrap_en) ns = 3;
      rl = p[2] || tk || (ns == 1 && m_state != 1);
      if (rl) begin
        m_el = 0;
        m_per = rate_of(int'(rate_sel)) + 1;
      end else if (m_state == 1) m_el++;
      m_clrb = !(p[2] || (term && wrap_en));
      m_q = (m_q + int'(en)) % 256;
      if (!m_clrb) m_q = 0;
      m_state = ns;
      h3 = h2; h2 = h1;
      h1 = {clear_n, stop_n, start_n};
    end
  end

  always @(negedge clock) begin
    if (m_ok) begin
      int ee;
      ee = (m_state == 1 && m_el == m_per - 1 &&
            m_q != int'(target) && m_clrb) ? 1 : 0;
      chk("m_state", int'(state), m_state);
      chk("m_clr_b", int'(count_clear_b), int'(m_clrb));
      chk("m_en", int'(count_en), ee);
      chk("m_busy", int'(busy), int'(m_state == 1));
      chk("m_done", int'(done), int'(m_state == 3));
      chk("m_q", int'(cq), m_q);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic press_clear();
    clear_n = 1'b0;
    step(); step();
    clear_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic press_start();
    start_n = 1'b0;
    step(); step();
    start_n = 1'b1;
    step();
  endtask

  task automatic wait_q(input int v, input int lim, input string nm);
    int i;
    i = 0;
    while (int'(cq) != v && i < lim) begin
      step();
      i++;
    end
    chk(nm, int'(cq), v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rc, ne, first, last, spbad, dcyc, bad;
    int nr, nc, dbl, over, reent, seen0;
    bit pl;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_clr_b", int'(count_clear_b), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_en", int'(count_en), 0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    step();
    chk("rel_clr_b", int'(count_clear_b), 1);
    chk("rel_state", int'(state), 0);

    // rate 3 cycles reload, stop at 5
    rate_sel = 2'd2; target = 8'd5; wrap_en = 1'b0;
    start_n = 1'b0;
    rc = 0; ne = 0; first = 0; last = 0;
    spbad = 0; dcyc = 0; bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (i == 3) start_n = 1'b1;
      if (busy) rc++;
      if (count_en) begin
        ne++;
        if (ne == 1) first = rc;
        else if (rc - last != 4) spbad++;
        last = rc;
      end
      if (done) begin
        dcyc++;
        if (count_en) bad++;
      end
    end
    chk("a_first_en", first, 4);
    chk("a_pulses", ne, 5);
    chk("a_spacing", spbad, 0);
    chk("a_q", int'(cq), 5);
    chk("a_state", int'(state), 3);
    chk("a_done_cycles", int'(dcyc >= 20), 1);
    chk("a_en_in_done", bad, 0);

    press_clear();
    chk("clr_state", int'(state), 0);
    chk("clr_q", int'(cq), 0);

    // pause at 4, resume to 9
    rate_sel = 2'd0; target = 8'd9;
    press_start();
    wait_q(1, 20, "b_reach1");
    stop_n = 1'b0;
    step(); step();
    stop_n = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (state != 2'd2 || cq != 8'd4) bad++;
    end
    chk("b_pause_q", int'(cq), 4);
    chk("b_pause_hold", bad, 0);
    start_n = 1'b0;
    ne = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (i == 2) start_n = 1'b1;
      if (count_en) ne++;
    end
    start_n = 1'b1;
    chk("b_resume_pulses", ne, 5);
    chk("b_q", int'(cq), 9);
    chk("b_state", int'(state), 3);

    // clear and start together while running
    press_clear();
    rate_sel = 2'd1; target = 8'd200;
    press_start();
    repeat (10) step();
    clear_n = 1'b0; start_n = 1'b0;
    nc = 0; reent = 0; seen0 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 2) begin
        clear_n = 1'b1; start_n = 1'b1;
      end
      if (!count_clear_b) nc++;
      if (state == 2'd0) seen0 = 1;
      else if (seen0) reent++;
    end
    chk("c_clr_cycles", nc, 1);
    chk("c_state", int'(state), 0);
    chk("c_q", int'(cq), 0);
    chk("c_reentry", reent, 0);

    // wrap at 3
    rate_sel = 2'd0; target = 8'd3; wrap_en = 1'b1;
    press_start();
    nr = 0; nc = 0; dbl = 0; over = 0; pl = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (state != 2'd1) nr++;
      if (!count_clear_b) begin
        nc++;
        if (pl) dbl++;
      end
      pl = !count_clear_b;
      if (cq > 8'd3) over++;
    end
    chk("d_not_run", nr, 0);
    chk("d_wraps", int'(nc >= 7), 1);
    chk("d_double_clr", dbl, 0);
    chk("d_over", over, 0);

    // target 0 stops after one RUN cycle
    press_clear();
    wrap_en = 1'b0; target = 8'd0;
    start_n = 1'b0;
    rc = 0; ne = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 2) start_n = 1'b1;
      if (busy) rc++;
      if (count_en) ne++;
    end
    chk("e_run_cycles", rc, 1);
    chk("e_pulses", ne, 0);
    chk("e_state", int'(state), 3);
    press_start();
    repeat (3) step();
    chk("e_start_ignored", int'(state), 3);

    // target moved below count: wrap through 255
    press_clear();
    target = 8'd200;
    press_start();
    wait_q(120, 200, "f_reach120");
    target = 8'd50;
    for (int i = 0; i < 400 && !done; i++) step();
    chk("f_done", int'(done), 1);
    chk("f_q", int'(cq), 50);

    // async reset while running
    press_clear();
    rate_sel = 2'd1; target = 8'd200;
    press_start();
    repeat (8) step();
    #2 reset_n = 1'b0;
    #1;
    chk("g_rst_state", int'(state), 0);
    chk("g_rst_en", int'(count_en), 0);
    chk("g_rst_clr_b", int'(count_clear_b), 0);
    step();
    reset_n = 1'b1;
    step(); step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rate_sel = 2'($urandom_range(0, 3));
      if (i % 150 == 0) begin
        target = 8'($urandom_range(0, 15));
        wrap_en = 1'($urandom_range(0, 1));
      end
      start_n = ($urandom_range(0, 7) != 0);
      stop_n = ($urandom_range(0, 24) != 0);
      clear_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 999) == 0) begin
        #1 reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      step();
    end
    start_n = 1'b1; stop_n = 1'b1; clear_n = 1'b1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
